// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, flag bit positions and FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_PASS  = 4'd0,
    OP_OR    = 4'd1,
    OP_XOR   = 4'd2,
    OP_AND   = 4'd3,
    OP_SHL   = 4'd4,
    OP_SHR   = 4'd5,
    OP_ADD   = 4'd6,
    OP_SUB   = 4'd7,
    OP_MUL   = 4'd8,
    OP_NEG   = 4'd9,
    OP_DIV   = 4'd10,
    OP_NOT   = 4'd11,
    OP_ASR   = 4'd12,
    OP_ROL   = 4'd13,
    OP_RSV14 = 4'd14,
    OP_RSV15 = 4'd15
  } alu_op_e;

  localparam int FLG_Z  = 0;
  localparam int FLG_N  = 1;
  localparam int FLG_C  = 2;
  localparam int FLG_V  = 3;
  localparam int FLG_DZ = 4;
  localparam int NFLG   = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } alu_st_e;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/opcode load bus and result/status return for alu_seq.
interface alu_seq_if #(parameter int WIDTH = 16) ();
  logic [WIDTH-1:0] din;
  logic             a_ld;
  logic             b_ld;
  logic [3:0]       op_in;
  logic             op_ld;
  logic             start;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [4:0]       flags;

  modport master (output din, a_ld, b_ld, op_in, op_ld, start,
                  input  busy, done, result, flags);
  modport slave  (input  din, a_ld, b_ld, op_in, op_ld, start,
                  output busy, done, result, flags);
endinterface

// File: rtl/alu_muldiv_iter.sv
// Shared iterative datapath: shift-add multiply or restoring divide, one bit per cycle.
// p holds {hi,lo} for MUL and {remainder,quotient/dividend} for DIV.
module alu_muldiv_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] p_q, p_d, p_step;
  logic [WIDTH-1:0]   opd_q, opd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               div_q, div_d;
  logic [WIDTH:0]     mac, r_sh, diff;
  logic               ge;

  always_comb begin
    mac  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, opd_q} : '0);
    r_sh = p_q[2*WIDTH-1:WIDTH-1];
    diff = r_sh - {1'b0, opd_q};
    // remainder stays below the divisor, so bit WIDTH of diff is exactly the borrow
    ge   = ~diff[WIDTH];
    if (div_q)
      p_step = {(ge ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0]), p_q[WIDTH-2:0], ge};
    else
      p_step = {mac, p_q[WIDTH-1:1]};
  end

  always_comb begin
    p_d   = p_q;
    opd_d = opd_q;
    cnt_d = cnt_q;
    div_d = div_q;
    if (start_i) begin
      p_d   = {{WIDTH{1'b0}}, a_i};
      opd_d = b_i;
      cnt_d = CW'(WIDTH);
      div_d = div_i;
    end else if (cnt_q != '0) begin
      p_d   = p_step;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q   <= '0;
      opd_q <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
    end else begin
      p_q   <= p_d;
      opd_q <= opd_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

  assign last_o = (cnt_q == CW'(1));
  assign lo_o   = p_step[WIDTH-1:0];
  assign hi_o   = p_step[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: operand/opcode registers, single-cycle ops, flag generation and
// the IDLE/ITER/DONE control FSM around the iterative mul/div datapath.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [NFLG-1:0]  flg_q, flg_d;
  alu_op_e          op_q, op_d;
  alu_st_e          st_q, st_d;

  logic             ld_en, accept, iter_go, b_zero;
  logic             it_last;
  logic [WIDTH-1:0] it_lo, it_hi;

  logic [WIDTH-1:0] sres;
  logic             scarry, sovf, sdivz;
  logic [SHW-1:0]   sh, rsh;
  logic [WIDTH:0]   shl_ext, add_w, sub_w;
  logic [WIDTH-1:0] neg_w;

  function automatic logic [NFLG-1:0] mk_flags(logic [WIDTH-1:0] r, logic c, logic v, logic dz);
    logic [NFLG-1:0] f;
    f         = '0;
    f[FLG_Z]  = (r == '0);
    f[FLG_N]  = r[WIDTH-1];
    f[FLG_C]  = c;
    f[FLG_V]  = v;
    f[FLG_DZ] = dz;
    return f;
  endfunction

  assign ld_en   = (st_q != ST_ITER);
  assign accept  = bus.start && (st_q != ST_ITER);
  assign b_zero  = (b_q == '0);
  assign iter_go = accept && ((op_q == OP_MUL) || ((op_q == OP_DIV) && !b_zero));

  always_comb begin
    a_d  = (bus.a_ld  && ld_en) ? bus.din : a_q;
    b_d  = (bus.b_ld  && ld_en) ? bus.din : b_q;
    op_d = (bus.op_ld && ld_en) ? alu_op_e'(bus.op_in) : op_q;
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst     (rst),
    .start_i (iter_go),
    .div_i   (op_q == OP_DIV),
    .a_i     (a_q),
    .b_i     (b_q),
    .last_o  (it_last),
    .lo_o    (it_lo),
    .hi_o    (it_hi)
  );

  // single-cycle ops; MUL never lands here, DIV only for the divide-by-zero case
  always_comb begin
    sh      = b_q[SHW-1:0];
    rsh     = -sh;
    shl_ext = {1'b0, a_q} << sh;
    add_w   = {1'b0, a_q} + {1'b0, b_q};
    sub_w   = {1'b0, a_q} - {1'b0, b_q};
    neg_w   = '0 - a_q;
    sres    = '0;
    scarry  = 1'b0;
    sovf    = 1'b0;
    sdivz   = 1'b0;
    case (op_q)
      OP_PASS: sres = a_q;
      OP_OR:   sres = a_q | b_q;
      OP_XOR:  sres = a_q ^ b_q;
      OP_AND:  sres = a_q & b_q;
      OP_SHL: begin
        sres   = shl_ext[WIDTH-1:0];
        scarry = shl_ext[WIDTH];
      end
      OP_SHR:  sres = a_q >> sh;
      OP_ADD: begin
        sres   = add_w[WIDTH-1:0];
        scarry = add_w[WIDTH];
        sovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        sres   = sub_w[WIDTH-1:0];
        scarry = sub_w[WIDTH];
        sovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_NEG: begin
        sres   = neg_w;
        scarry = (a_q != '0);
        sovf   = a_q[WIDTH-1] && neg_w[WIDTH-1];
      end
      OP_DIV: begin
        sres   = '1;
        sdivz  = 1'b1;
      end
      OP_NOT:  sres = ~a_q;
      OP_ASR:  sres = WIDTH'($signed(a_q) >>> sh);
      OP_ROL:  sres = (a_q << sh) | (a_q >> rsh);
      default: sres = '0;
    endcase
  end

  always_comb begin
    res_d = res_q;
    flg_d = flg_q;
    if ((st_q == ST_ITER) && it_last) begin
      res_d = it_lo;
      flg_d = mk_flags(it_lo, 1'b0, (op_q == OP_MUL) && (it_hi != '0), 1'b0);
    end else if (accept && !iter_go) begin
      res_d = sres;
      flg_d = mk_flags(sres, scarry, sovf, sdivz);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= OP_PASS;
      res_q <= '0;
      flg_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      res_q <= res_d;
      flg_q <= flg_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= ST_IDLE;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE, ST_DONE: begin
        if (accept) st_d = iter_go ? ST_ITER : ST_DONE;
        else        st_d = ST_IDLE;
      end
      ST_ITER: if (it_last) st_d = ST_DONE;
      default: st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy   = (st_q == ST_ITER);
    bus.done   = (st_q == ST_DONE);
    bus.result = res_q;
    bus.flags  = flg_q;
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: hand-computed vectors, latency and mid-operation rules.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(16)) bus ();
  alu_seq #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic [15:0] res;
    logic [4:0]  flg;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
    bus.din  = a;
    bus.a_ld = 1'b1;
    step();
    bus.a_ld  = 1'b0;
    bus.din   = b;
    bus.b_ld  = 1'b1;
    bus.op_in = op;
    bus.op_ld = 1'b1;
    step();
    bus.b_ld  = 1'b0;
    bus.op_ld = 1'b0;
  endtask

  task automatic fire();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat  = 1;
    bcnt = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) bcnt++;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vec_cnt++;
    if ({bus.busy, bus.done, bus.result, bus.flags} !== 23'd0) begin
      err_cnt++;
      $display("FAIL reset_outs got busy=%b done=%b res=%h flg=%b want all 0",
               bus.busy, bus.done, bus.result, bus.flags);
    end
    rst = 1'b0;
    step();
    vec_cnt++;
    if ({bus.busy, bus.done, bus.result, bus.flags} !== 23'd0) begin
      err_cnt++;
      $display("FAIL reset_release got busy=%b done=%b res=%h flg=%b want all 0",
               bus.busy, bus.done, bus.result, bus.flags);
    end
  endtask

  task automatic test_simple();
    vec_t tbl[19];
    int lat, bcnt;
    tbl = '{
      '{16'hFFFF, 16'h0001, 4'd6,  16'h0000, 5'b00101},
      '{16'h7FFF, 16'h0001, 4'd6,  16'h8000, 5'b01010},
      '{16'h0005, 16'h0007, 4'd7,  16'hFFFE, 5'b00110},
      '{16'h8000, 16'h0001, 4'd7,  16'h7FFF, 5'b01000},
      '{16'h8000, 16'h0003, 4'd12, 16'hF000, 5'b00010},
      '{16'h8000, 16'h0003, 4'd5,  16'h1000, 5'b00000},
      '{16'h8001, 16'h0001, 4'd4,  16'h0002, 5'b00100},
      '{16'h0001, 16'h0014, 4'd4,  16'h0010, 5'b00000},
      '{16'h8001, 16'h0004, 4'd13, 16'h0018, 5'b00000},
      '{16'h8001, 16'h0010, 4'd13, 16'h8001, 5'b00010},
      '{16'h8000, 16'h0000, 4'd9,  16'h8000, 5'b01110},
      '{16'h0000, 16'h0000, 4'd9,  16'h0000, 5'b00001},
      '{16'hF0F0, 16'hFF00, 4'd2,  16'h0FF0, 5'b00000},
      '{16'hF0F0, 16'hFF00, 4'd3,  16'hF000, 5'b00010},
      '{16'h00F0, 16'h0F00, 4'd1,  16'h0FF0, 5'b00000},
      '{16'h00FF, 16'h0000, 4'd11, 16'hFF00, 5'b00010},
      '{16'h0000, 16'h1234, 4'd0,  16'h0000, 5'b00001},
      '{16'h1234, 16'h5678, 4'd14, 16'h0000, 5'b00001},
      '{16'h1234, 16'h5678, 4'd15, 16'h0000, 5'b00001}
    };
    for (int i = 0; i < 19; i++) begin
      load(tbl[i].a, tbl[i].b, tbl[i].op);
      fire();
      wait_done(lat, bcnt);
      vec_cnt++;
      if (lat !== 1 || bcnt !== 0) begin
        err_cnt++;
        $display("FAIL simple_lat[%0d] op=%0d got lat=%0d busy=%0d want lat=1 busy=0",
                 i, tbl[i].op, lat, bcnt);
      end
      vec_cnt++;
      if (bus.result !== tbl[i].res || bus.flags !== tbl[i].flg) begin
        err_cnt++;
        $display("FAIL simple[%0d] op=%0d got res=%h flg=%b want res=%h flg=%b",
                 i, tbl[i].op, bus.result, bus.flags, tbl[i].res, tbl[i].flg);
      end
      step();
    end
  endtask

  task automatic test_iterative(input string nm, input logic [15:0] a, input logic [15:0] b,
                                input logic [3:0] op, input logic [15:0] res, input logic [4:0] flg);
    int lat, bcnt;
    load(a, b, op);
    fire();
    wait_done(lat, bcnt);
    vec_cnt++;
    if (lat !== 17 || bcnt !== 16 || bus.busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s_timing got lat=%0d busy_cycles=%0d busy_at_done=%b want 17/16/0",
               nm, lat, bcnt, bus.busy);
    end
    vec_cnt++;
    if (bus.result !== res || bus.flags !== flg) begin
      err_cnt++;
      $display("FAIL %s got res=%h flg=%b want res=%h flg=%b", nm, bus.result, bus.flags, res, flg);
    end
    step();
  endtask

  task automatic test_mul();
    test_iterative("mul_ovf", 16'h0100, 16'h0100, 4'd8, 16'h0000, 5'b01001);
    test_iterative("mul",     16'h00FF, 16'h0003, 4'd8, 16'h02FD, 5'b00000);
  endtask

  task automatic test_div();
    test_iterative("div",      16'd100,  16'd7,    4'd10, 16'h000E, 5'b00000);
    test_iterative("div_max",  16'hFFFF, 16'h0001, 4'd10, 16'hFFFF, 5'b00010);
    test_iterative("div_zero", 16'd5,    16'd9,    4'd10, 16'h0000, 5'b00001);
  endtask

  task automatic test_divz();
    int lat, bcnt;
    load(16'h1234, 16'h0000, 4'd10);
    fire();
    wait_done(lat, bcnt);
    vec_cnt++;
    if (lat !== 1 || bcnt !== 0 || bus.result !== 16'hFFFF || bus.flags !== 5'b10010) begin
      err_cnt++;
      $display("FAIL divz got lat=%0d busy=%0d res=%h flg=%b want lat=1 busy=0 res=ffff flg=10010",
               lat, bcnt, bus.result, bus.flags);
    end
    step();
  endtask

  task automatic test_iter_ignore();
    int lat, bcnt;
    load(16'd100, 16'd7, 4'd10);
    fire();
    repeat (3) step();
    bus.start = 1'b1; bus.a_ld = 1'b1; bus.b_ld = 1'b1; bus.op_ld = 1'b1;
    bus.din = 16'h0003; bus.op_in = 4'd6;
    step();
    bus.start = 1'b0; bus.a_ld = 1'b0; bus.b_ld = 1'b0; bus.op_ld = 1'b0;
    wait_done(lat, bcnt);
    vec_cnt++;
    if (lat !== 13 || bcnt !== 12 || bus.result !== 16'h000E) begin
      err_cnt++;
      $display("FAIL iter_ignore got lat=%0d busy=%0d res=%h want lat=13 busy=12 res=000e",
               lat, bcnt, bus.result);
    end
    step();
    vec_cnt++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      err_cnt++;
      $display("FAIL iter_no_queue got busy=%b done=%b want 0/0", bus.busy, bus.done);
    end
    fire();
    wait_done(lat, bcnt);
    vec_cnt++;
    if (lat !== 17 || bus.result !== 16'h000E || bus.flags !== 5'b00000) begin
      err_cnt++;
      $display("FAIL iter_regs_kept got lat=%0d res=%h flg=%b want lat=17 res=000e flg=00000",
               lat, bus.result, bus.flags);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int lat, bcnt, dcnt;
    load(16'd1000, 16'd3, 4'd10);
    fire();
    repeat (4) step();
    rst = 1'b1;
    #2;
    vec_cnt++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 16'h0 || bus.flags !== 5'b0) begin
      err_cnt++;
      $display("FAIL rst_mid got busy=%b done=%b res=%h flg=%b want 0/0/0000/00000",
               bus.busy, bus.done, bus.result, bus.flags);
    end
    step();
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done || bus.busy) dcnt++;
      step();
    end
    vec_cnt++;
    if (dcnt !== 0 || bus.result !== 16'h0) begin
      err_cnt++;
      $display("FAIL rst_mid_no_done got active_cycles=%0d res=%h want 0/0000", dcnt, bus.result);
    end
    bus.din = 16'h0000;
    fire();
    wait_done(lat, bcnt);
    vec_cnt++;
    if (lat !== 1 || bus.result !== 16'h0000 || bus.flags !== 5'b00001) begin
      err_cnt++;
      $display("FAIL rst_mid_cleared got lat=%0d res=%h flg=%b want lat=1 res=0000 flg=00001",
               lat, bus.result, bus.flags);
    end
    step();
  endtask

  task automatic test_back_to_back();
    load(16'd3, 16'd4, 4'd6);
    bus.start = 1'b1;
    step();
    bus.op_in = 4'd7;
    bus.op_ld = 1'b1;
    vec_cnt++;
    if (bus.done !== 1'b1 || bus.result !== 16'h0007) begin
      err_cnt++;
      $display("FAIL b2b_first got done=%b res=%h want 1/0007", bus.done, bus.result);
    end
    step();
    bus.start = 1'b0;
    bus.op_ld = 1'b0;
    vec_cnt++;
    if (bus.done !== 1'b1 || bus.result !== 16'h0007 || bus.flags !== 5'b00000) begin
      err_cnt++;
      $display("FAIL b2b_second got done=%b res=%h flg=%b want 1/0007/00000",
               bus.done, bus.result, bus.flags);
    end
    step();
    vec_cnt++;
    if (bus.done !== 1'b0) begin
      err_cnt++;
      $display("FAIL b2b_idle got done=%b want 0", bus.done);
    end
    fire();
    vec_cnt++;
    if (bus.done !== 1'b1 || bus.result !== 16'hFFFF || bus.flags !== 5'b00110) begin
      err_cnt++;
      $display("FAIL b2b_new_op got done=%b res=%h flg=%b want 1/ffff/00110",
               bus.done, bus.result, bus.flags);
    end
    step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.din = '0; bus.a_ld = 1'b0; bus.b_ld = 1'b0;
    bus.op_in = '0; bus.op_ld = 1'b0; bus.start = 1'b0;
    #1;
    test_reset();
    test_simple();
    test_mul();
    test_div();
    test_divz();
    test_iter_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU for the stack datapath. Operands A and B and a 4-bit opcode are loaded into internal registers from the shared data bus. The block then executes on a `start` pulse. Simple operations complete in one cycle. Multiply and divide run iteratively over WIDTH cycles. It returns a registered result, status flags and a one-cycle `done` pulse, and asserts `busy` while an iterative operation is in flight.

## Interface
- `WIDTH`, 16, datapath width. Must be a power of two, ≥ 4.
- `SHW`, log2(WIDTH), derived shift-amount width. Not overridable.
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `din`  in  WIDTH  operand bus.
- `a_ld`  in  1  load `din` into A.
- `b_ld`  in  1  load `din` into B.
- `op_in`  in  4  opcode.
- `op_ld`  in  1  load `op_in` into the opcode register.
- `start`  in  1  begin executing the registered opcode on A and B.
- `busy`  out  1  iterative operation in progress.
- `done`  out  1  one-cycle pulse when `result` and `flags` update.
- `result`  out  WIDTH  registered result, held until the next `done`.
- `flags`  out  5  {divz, ovf, carry, neg, zero}, registered, held with `result`.

## Operation
- Opcodes:
  - 0 PASS A, 1 OR, 2 XOR, 3 AND.
  - 4 SHL A by B[SHW-1:0], 5 SHR (logical), 6 ADD, 7 SUB (A−B).
  - 8 MUL (unsigned, low WIDTH bits), 9 NEG (0−A), 10 DIV (unsigned quotient A/B), 11 NOT A.
  - 12 ASR, 13 ROL by B[SHW-1:0].
  - 14–15 reserved: result 0, flags reflect zero.
- Loads:
  - `a_ld`, `b_ld` and `op_ld` are independent and may assert together.
  - Loads are ignored while `busy`=1.
  - When a load and `start` occur at the same edge, the operation uses the pre-edge register values; the loaded values serve the next operation.
- FSM has three states: IDLE, ITER, DONE.
  - IDLE + `start`, simple opcode: compute combinationally, register result and flags, go to DONE.
  - IDLE + `start`, MUL: go to ITER with count=WIDTH, using a shift-add multiplier.
  - IDLE + `start`, DIV with B≠0: go to ITER with count=WIDTH, using a restoring divider.
  - IDLE + `start`, DIV with B=0: result all-ones, divz=1, go to DONE. No iteration.
  - ITER: one iteration per cycle, count decrements. At count=1, register result and flags, go to DONE.
  - DONE: `done`=1 for this single cycle. Returns to IDLE. `start` is accepted in DONE, with the same transitions as IDLE, so back-to-back operations are possible.
  - `start` in ITER is ignored and is not queued.
- Flags:
  - zero = (result==0); neg = result[WIDTH-1].
  - carry: ADD carry-out; SUB and NEG borrow (A<B, or A≠0 for NEG); SHL last bit shifted out. Otherwise 0.
  - ovf: signed overflow for ADD, SUB and NEG; MUL when the high half of the full product is nonzero. Otherwise 0.
  - divz: only for DIV with B=0.
- Reset mid-operation aborts. No `done` is issued for the aborted operation.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `flags`=0. A, B, opcode, counter and FSM are all cleared; FSM goes to IDLE.
- Let N be the edge at which `start` is sampled.
- Simple ops and DIV-by-zero: `done`=1 in the cycle after edge N+1 (latency 1).
- MUL and DIV: `busy`=1 after edges N+1 … N+WIDTH. `done`=1 after edge N+WIDTH+1 (latency WIDTH+1, i.e. 17 at WIDTH=16). `busy` and `done` are never high together.
- `result` and `flags` change only at the edge that raises `done`.

## Structure
- Shared package `alu_pkg`:
  - opcode enum `alu_op_e` (values above);
  - flag bit index constants `FLG_Z`, `FLG_N`, `FLG_C`, `FLG_V`, `FLG_DZ`;
  - FSM state enum.
- One sub-module, `alu_muldiv_iter`. It holds the shared shift-add / restoring-divide datapath with start, mode, count and done-strobe. The top level keeps the operand and opcode registers, the combinational simple ops, the flag logic and the FSM.

## Test plan
- ADD: A=0xFFFF, B=0x0001, start → one cycle later `done`; result 0x0000, zero=1, carry=1, ovf=0.
- SUB: A=5, B=7 → result 0xFFFE, carry=1, neg=1. ASR: A=0x8000, B=3 → 0xF000.
- MUL: A=0x0100, B=0x0100 → `busy` for exactly 16 cycles, then `done`; result 0x0000, ovf=1. Also 0x00FF×0x0003 → 0x02FD, ovf=0.
- DIV: 100/7 → 0x000E after 17 cycles. DIV by 0 → 0xFFFF, divz=1, latency 1.
- Mid-operation rules, checked during a DIV:
  - `start`, `a_ld` and `op_ld` asserted in ITER → ignored, registers unchanged.
  - `rst` at cycle 5 of ITER → `busy`=0, no `done`, result 0.
- Back-to-back: `start` in the DONE cycle with a new opcode loaded the same edge → previous opcode executes; the new opcode executes on the following `start`.
